// File: rtl/router_pkg.sv
// Shared definitions for the ingress queue and the 4-way combinational router.
package router_pkg;

  localparam int unsigned ROUTER_PORTS  = 4;
  localparam int unsigned ROUTER_ADDR_W = 2;

  typedef logic [ROUTER_ADDR_W-1:0] router_addr_t;

  // Occupancy counter width able to hold the value DEPTH itself.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_ingress_queue_if.sv
// Upstream handshake, router-facing issue bus and status of the ingress queue.
interface router_ingress_queue_if
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
);

  localparam int unsigned CNT_W = count_width(DEPTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  router_addr_t            in_addr;
  logic [ROUTER_PORTS-1:0] dest_ready;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    dout_en;
  router_addr_t            dout_addr;
  logic [CNT_W-1:0]        count;
  logic                    hol_stall;

  modport master (
    output in_valid, in_data, in_addr, dest_ready,
    input  in_ready, dout, dout_en, dout_addr, count, hol_stall
  );

  modport slave (
    input  in_valid, in_data, in_addr, dest_ready,
    output in_ready, dout, dout_en, dout_addr, count, hol_stall
  );

endinterface

// File: rtl/router_fifo.sv
// Synchronous FIFO with power-of-2 depth; read data is the current head (show-ahead).
module router_fifo #(
  parameter  int unsigned WIDTH = 34,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents beyond the pointers are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/router_ingress_queue.sv
// In-order ingress queue feeding the combinational router, issuing only to ready outputs.
module router_ingress_queue
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  router_ingress_queue_if.slave bus
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + ROUTER_ADDR_W;
  localparam int unsigned CNT_W   = count_width(DEPTH);

  logic [ENTRY_W-1:0]    head;
  logic [DATA_WIDTH-1:0] head_data;
  router_addr_t          head_addr;
  logic [CNT_W-1:0]      occupancy;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  head_dest_ready;

  assign {head_addr, head_data} = head;

  // Acceptance depends on occupancy only, never on a same-cycle pop.
  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & ~full;

  assign head_dest_ready = bus.dest_ready[head_addr];
  assign pop             = ~empty & head_dest_ready;
  assign bus.hol_stall   = ~empty & ~head_dest_ready;
  assign bus.count       = occupancy;

  router_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_addr, bus.in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  // Issue register: one-cycle pulse carrying the popped head, zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout      <= '0;
      bus.dout_addr <= '0;
      bus.dout_en   <= 1'b0;
    end else if (pop) begin
      bus.dout      <= head_data;
      bus.dout_addr <= head_addr;
      bus.dout_en   <= 1'b1;
    end else begin
      bus.dout      <= '0;
      bus.dout_addr <= '0;
      bus.dout_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_ingress_queue.sv
// Directed, table-driven bench for router_ingress_queue.
module tb_router_ingress_queue;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  router_ingress_queue_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

  router_ingress_queue #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic [1:0]  addr;
    logic [3:0]  dr;
    logic        e_en;
    logic [31:0] e_dout;
    logic [1:0]  e_addr;
    logic [3:0]  e_cnt;
    logic        e_rdy;
    logic        e_hol;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  logic [33:0] mq [$];

  function automatic vec_t mk(input logic vld, input logic [31:0] data, input logic [1:0] addr,
                              input logic [3:0] dr, input logic e_en, input logic [31:0] e_dout,
                              input logic [1:0] e_addr, input logic [3:0] e_cnt,
                              input logic e_rdy, input logic e_hol);
    vec_t v;
    v.vld = vld; v.data = data; v.addr = addr; v.dr = dr;
    v.e_en = e_en; v.e_dout = e_dout; v.e_addr = e_addr;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_hol = e_hol;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic [31:0] d,
                         input logic [1:0] a, input logic [3:0] c, input logic r, input logic h);
    chk({tag, " dout_en"},   32'(bus.dout_en),   32'(en));
    chk({tag, " dout"},      bus.dout,           d);
    chk({tag, " dout_addr"}, 32'(bus.dout_addr), 32'(a));
    chk({tag, " count"},     32'(bus.count),     32'(c));
    chk({tag, " in_ready"},  32'(bus.in_ready),  32'(r));
    chk({tag, " hol_stall"}, 32'(bus.hol_stall), 32'(h));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] a, input logic [3:0] dr);
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_addr    = a;
    bus.dest_ready = dr;
  endtask

  initial begin
    logic [33:0] exp_w;
    logic        m_push;
    logic        m_pop;
    int          k;

    checks = 0;
    errors = 0;

    // Main single-word, blocked-head and push+pop vectors, checked 1 time unit after each edge.
    vt[0]  = mk(1, 32'hA5A5A5A5, 2, 4'hF, 0, 32'h0,        0, 1, 1, 0);
    vt[1]  = mk(0, 32'h0,        0, 4'hF, 1, 32'hA5A5A5A5, 2, 0, 1, 0);
    vt[2]  = mk(0, 32'h0,        0, 4'hF, 0, 32'h0,        0, 0, 1, 0);
    vt[3]  = mk(1, 32'h11,       1, 4'h8, 0, 32'h0,        0, 1, 1, 1);
    vt[4]  = mk(1, 32'h33,       3, 4'h8, 0, 32'h0,        0, 2, 1, 1);
    vt[5]  = mk(0, 32'h0,        0, 4'h8, 0, 32'h0,        0, 2, 1, 1);
    vt[6]  = mk(0, 32'h0,        0, 4'hA, 1, 32'h11,       1, 1, 1, 0);
    vt[7]  = mk(0, 32'h0,        0, 4'hA, 1, 32'h33,       3, 0, 1, 0);
    vt[8]  = mk(0, 32'h0,        0, 4'h0, 0, 32'h0,        0, 0, 1, 0);
    vt[9]  = mk(1, 32'h44,       0, 4'h0, 0, 32'h0,        0, 1, 1, 1);
    vt[10] = mk(1, 32'h55,       0, 4'h1, 1, 32'h44,       0, 1, 1, 0);
    vt[11] = mk(0, 32'h0,        0, 4'h1, 1, 32'h55,       0, 0, 1, 0);
    vt[12] = mk(0, 32'h0,        0, 4'h0, 0, 32'h0,        0, 0, 1, 0);

    // Reset held with in_valid high: queue stays empty and silent.
    reset = 1'b1;
    drive(1, 32'hDEADBEEF, 1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("rst_hold%0d", i), 0, 32'h0, 0, 0, 1, 0);
    end
    reset = 1'b0;
    drive(0, 32'h0, 0, 4'hF);
    #1;
    chk_all("rst_release", 0, 32'h0, 0, 0, 1, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].vld, vt[i].data, vt[i].addr, vt[i].dr);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_en, vt[i].e_dout, vt[i].e_addr,
              vt[i].e_cnt, vt[i].e_rdy, vt[i].e_hol);
    end

    // Fill to full with all destinations blocked.
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + 32'(i), 2'(i), 4'h0);
      mq.push_back({2'(i), 32'h100 + 32'(i)});
      step();
    end
    chk_all("full", 0, 32'h0, 0, 8, 0, 1);
    drive(1, 32'h1FF, 3, 4'h0);
    step();
    chk("ninth_refused count", 32'(bus.count), 32'd8);
    chk("ninth_refused in_ready", 32'(bus.in_ready), 32'd0);

    // Drain from full with continuous input; order preserved across pointer wrap.
    k = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1, 32'h200 + 32'(k), 2'(k), 4'hF);
      m_push = (mq.size() != 8);
      m_pop  = (mq.size() != 0);
      step();
      exp_w = 34'h0;
      if (m_pop) exp_w = mq.pop_front();
      if (m_push) begin
        mq.push_back({2'(k), 32'h200 + 32'(k)});
        k++;
      end
      chk($sformatf("stream%0d dout_en", c), 32'(bus.dout_en), 32'(m_pop));
      chk($sformatf("stream%0d dout", c), bus.dout, exp_w[31:0]);
      chk($sformatf("stream%0d dout_addr", c), 32'(bus.dout_addr), 32'(exp_w[33:32]));
      chk($sformatf("stream%0d count", c), 32'(bus.count), 32'(mq.size()));
    end

    // Drain, then queue 6, issue one, and reset mid-pulse with 5 queued.
    drive(0, 32'h0, 0, 4'hF);
    for (int i = 0; i < 10; i++) step();
    mq.delete();
    chk("drained count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h300 + 32'(i), 2'(i), 4'h0);
      step();
    end
    drive(0, 32'h0, 0, 4'hF);
    step();
    chk_all("pre_reset", 1, 32'h300, 0, 5, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 32'h0, 0, 0, 1, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("post_reset%0d", i), 0, 32'h0, 0, 0, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
